imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed, little-endian 32-bit instruction memory.
- Accepts a byte stream over a valid/ready handshake (from the UART/debug front end) and assembles 4 bytes per instruction word.
- Issues one word write per instruction into the memory's write port.
- Holds the CPU in reset until the image is completely loaded.

Parameters:
- DEPTH, 1024, instruction memory size in bytes; the largest legal image is DEPTH/4 words.
- WIDTH, 8, byte width; the word width is 4*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_data  input  WIDTH  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; a handshake is in_valid & in_ready on a clock edge.
- mem_we  output  1  word write strobe to the instruction memory.
- mem_addr  output  4*WIDTH  byte address of the write; always word-aligned (bits [1:0] = 0).
- mem_wdata  output  4*WIDTH  write word; byte 0 in bits [WIDTH-1:0].
- cpu_rst_n  output  1  active-low reset to the CPU core.
- busy  output  1  a load is in progress.
- done  output  1  the last load completed successfully.
- err  output  1  the last load was rejected.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - All outputs are 0, including cpu_rst_n (CPU held in reset).
  - Internal counters and the assembly register are cleared.
- Stream format:
  - Two length bytes, LEN[7:0] then LEN[15:8], giving the word count N.
  - Then 4*N data bytes, lowest-address byte first.
- IDLE: in_ready=0. On start, go to LEN_LO and set busy=1.
- LEN_LO: in_ready=1. On handshake, capture the low length byte and go to LEN_HI.
- LEN_HI: in_ready=1. On handshake, capture the high length byte, then:
  - if N=0, go to DONE;
  - else if 4*N > DEPTH, go to ERR (compare using at least 18 bits, no truncation);
  - else set addr=0, words_left=N, lane=0 and go to DATA.
- DATA: in_ready=1. Each handshake writes in_data into byte lane `lane` of the assembly register, then lane increments.
  - The handshake at lane=3 goes to WRITE.
  - When in_valid=0, state is held indefinitely with no timeout.
- WRITE: in_ready=0. mem_we=1 for exactly this one cycle, with mem_addr=addr and mem_wdata=the assembled word. Then:
  - addr += 4, words_left -= 1, lane = 0;
  - if words_left reaches 0, go to DONE, else go back to DATA.
- Timing: each word costs at least 5 cycles (4 accept cycles + 1 write cycle). mem_addr and mem_wdata are registered and stable while mem_we=1.
- DONE:
  - busy=0, done=1, err=0.
  - cpu_rst_n=1 from the first DONE cycle.
  - Remains here until the next start.
- ERR:
  - busy=0, err=1, done=0.
  - cpu_rst_n=0.
  - No further memory writes; remains here until start.
- start from DONE or ERR:
  - go to LEN_LO;
  - done and err are cleared and cpu_rst_n drops to 0 on the same edge.
- start while busy=1 is ignored.
- Bytes presented in IDLE, DONE or ERR are not accepted (in_ready=0).
- Address wrap is impossible; the length check guarantees the last write address is 4*N-4 ≤ DEPTH-4.
- Reset during a load:
  - The loader aborts immediately to IDLE with cpu_rst_n=0.
  - Memory contents already written are left as-is.
  - The partially assembled word is discarded.
- mem_we is never asserted outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - One checksum byte follows the data bytes.
  - The loader keeps a running XOR of all 4*N data bytes, cleared on entry to LEN_LO.
  - After the final WRITE the loader enters CHK (in_ready=1). On handshake, a match goes to DONE and a mismatch goes to ERR.
  - For N=0 the checksum byte is still expected and must be 0x00.
  - ERR keeps cpu_rst_n=0. Words already written stay in memory.
- When not defined: no CHK state and no trailing byte; the final WRITE goes directly to DONE.

Test Plan:
1. Reset, then start, then stream 02 00 | 13 00 00 00 | 08 00 00 00, with in_valid held high:
   - mem_we pulses twice: addr 0x0 with wdata 0x00000013, and addr 0x4 with wdata 0x00000008;
   - then done=1 and cpu_rst_n=1.
2. Length 01 01 (N=257, 1028 bytes > 1024):
   - ERR after the second byte, err=1;
   - mem_we is never asserted; cpu_rst_n=0.
3. Length 00 01 (N=256), data bytes with deliberate gaps on in_valid:
   - exactly 256 writes, last at addr 0x3FC;
   - state is held during gaps; done=1.
4. Assert rst_n=0 after 2 of 4 data bytes of word 1:
   - all outputs 0 asynchronously;
   - a restart with N=1 (bytes AA BB CC DD) writes 0xDDCCBBAA at addr 0.
5. From DONE, pulse start:
   - cpu_rst_n falls and done clears on the same edge;
   - a start pulse during DATA changes nothing.
6. (IMEM_LOADER_CHECKSUM_EN) Stream N=1, bytes 01 02 04 08, checksum 0x0F, giving done=1. The same stream with checksum 0x0E gives err=1 and cpu_rst_n=0, even though the write at addr 0 still occurred.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a byte stream over a valid/ready handshake. The stream is a 16-bit word
// count (low byte first) followed by the data bytes, least-significant byte of
// each word first. Each complete word is written to the instruction memory, and
// the CPU stays in reset until the whole image has been loaded.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the data bytes.
module imem_loader #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [4*WIDTH-1:0] mem_addr,
    output logic [4*WIDTH-1:0] mem_wdata,
    output logic               cpu_rst_n,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned AW = 4 * WIDTH;
    localparam int unsigned LW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_ERR,
        S_CHK
`else
        S_ERR
`endif
    } state_t;

    // State entered once the data bytes are finished (or when the length is zero).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t          state_q, state_d;
    logic            hs;
    logic            launch;
    logic [LW-1:0]   n_in;
    logic            len_too_big;
    logic [WIDTH-1:0] len_lo_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   word_q;
    logic [LW-1:0]   words_left_q;
    logic [1:0]      lane_q;
    logic            rdy_d, we_d, busy_d, done_d, err_d, cpu_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] chk_q;
`endif

    assign hs          = in_valid & in_ready;
    assign n_in        = {in_data, len_lo_q};
    assign len_too_big = (64'(n_in) << 2) > 64'(DEPTH);
    assign mem_addr    = addr_q;
    assign mem_wdata   = word_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, plus output values decoded from the next state
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        rdy_d   = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cpu_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    launch  = 1'b1;
                end
            end
            S_LEN_LO: if (hs) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (hs) begin
                    if (n_in == '0)       state_d = S_TAIL;
                    else if (len_too_big) state_d = S_ERR;
                    else                  state_d = S_DATA;
                end
            end
            S_DATA:  if (hs && lane_q == 2'd3) state_d = S_WRITE;
            S_WRITE: state_d = (words_left_q == LW'(1)) ? S_TAIL : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:   if (hs) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_LEN_LO, S_LEN_HI, S_DATA: begin
                rdy_d  = 1'b1;
                busy_d = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                rdy_d  = 1'b1;
                busy_d = 1'b1;
            end
`endif
            S_WRITE: begin
                we_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                cpu_d  = 1'b1;
            end
            S_ERR:   err_d = 1'b1;
            default: ;
        endcase
    end

    // Registered control outputs, so they always match the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            in_ready  <= rdy_d;
            mem_we    <= we_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            cpu_rst_n <= cpu_d;
        end
    end

    // Length capture, word assembly, and write address / word counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q     <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            words_left_q <= '0;
            lane_q       <= '0;
        end else begin
            case (state_q)
                S_LEN_LO: if (hs) len_lo_q <= in_data;
                S_LEN_HI: begin
                    if (hs) begin
                        addr_q       <= '0;
                        words_left_q <= n_in;
                        lane_q       <= '0;
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        for (int i = 0; i < 4; i++) begin
                            if (lane_q == 2'(i)) word_q[i*WIDTH +: WIDTH] <= in_data;
                        end
                        lane_q <= lane_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    addr_q       <= addr_q + AW'(4);
                    words_left_q <= words_left_q - LW'(1);
                    lane_q       <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of the data bytes; it restarts with each new load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    chk_q <= '0;
        else if (launch)               chk_q <= '0;
        else if (state_q == S_DATA && hs) chk_q <= chk_q ^ in_data;
    end
`else
    logic unused_launch;
    assign unused_launch = launch;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. It applies a cycle-by-cycle vector table for the
// basic two-word load, then runs hand-written sequences for the multi-cycle cases.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    // Written only by the write monitor
    int          wr_count  = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    int          align_bad = 0;
    int          pat_bad   = 0;
    // Written only by the stimulus process
    logic        pat_on    = 1'b0;
    int          pat_base  = 0;

    imem_loader #(.DEPTH(1024), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pb(input int k);
        return 8'(k * 5 + 1);
    endfunction

    // Record every memory write, and check each one against the long-image pattern while that pattern is active
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr[1:0] != 2'b00) align_bad++;
            if (pat_on) begin
                if (mem_addr != 32'((wr_count - pat_base) * 4)) pat_bad++;
                if (mem_wdata != {pb(int'(mem_addr) + 3), pb(int'(mem_addr) + 2),
                                  pb(int'(mem_addr) + 1), pb(int'(mem_addr))}) pat_bad++;
            end
            wr_count++;
            last_addr = mem_addr;
            last_data = mem_wdata;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we",   32'(mem_we),   0);
        check("rst_mem_addr", mem_addr,      0);
        check("rst_wdata",    mem_wdata,     0);
        check("rst_status",   {28'd0, busy, done, err, cpu_rst_n}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte and hold it until the loader accepts it, giving up after a bounded number of cycles
    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: byte 0x%02h not accepted, in_ready=%0b", d, in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Complete a load once the last data byte has been sent: pass through WRITE, then send the checksum byte if that feature is built in
    task automatic finish_load(input logic [7:0] chk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(chk);
`else
        if (chk == 8'hff) $display("note: unused checksum byte");
        tick();
`endif
    endtask

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        busy;
        logic        done;
        logic        err;
        logic        cpu;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                                input logic rdy, input logic we, input logic [31:0] a,
                                input logic [31:0] w, input logic b, input logic dn,
                                input logic e, input logic c);
        vec_t r;
        r.start = s; r.valid = v; r.data = d; r.rdy = rdy; r.we = we; r.addr = a;
        r.wdata = w; r.busy = b; r.done = dn; r.err = e; r.cpu = c;
        return r;
    endfunction

    initial begin
        int base;
        logic [7:0] x;

        // Columns: start valid data | ready we addr wdata busy done err cpu_rst_n
        tv.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h02, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h13, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 0, 1, 32'h0, 32'h13,   1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h08, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h08, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 0, 1, 32'h4, 32'h08,   1, 0, 0, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
        tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0,            1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h1b, 0, 0, 0, 0,            0, 1, 0, 1));
`else
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0,            0, 1, 0, 1));
`endif
        tv.push_back(mk(0, 1, 8'h55, 0, 0, 0, 0,            0, 1, 0, 1));

        // Two-word load driven by the vector table
        do_reset();
        base = wr_count;
        foreach (tv[i]) begin
            start    = tv[i].start;
            in_valid = tv[i].valid;
            in_data  = tv[i].data;
            tick();
            check($sformatf("t1_row%0d_ready", i), 32'(in_ready), 32'(tv[i].rdy));
            check($sformatf("t1_row%0d_we", i),    32'(mem_we),   32'(tv[i].we));
            check($sformatf("t1_row%0d_status", i), {28'd0, busy, done, err, cpu_rst_n},
                  {28'd0, tv[i].busy, tv[i].done, tv[i].err, tv[i].cpu});
            if (tv[i].we) begin
                check($sformatf("t1_row%0d_addr", i),  mem_addr,  tv[i].addr);
                check($sformatf("t1_row%0d_wdata", i), mem_wdata, tv[i].wdata);
            end
        end
        in_valid = 1'b0;
        check("t1_write_count", 32'(wr_count - base), 2);

        // Oversized length (N=257) is rejected
        pulse_start();
        base = wr_count;
        send_byte(8'h01);
        send_byte(8'h01);
        check("t2_err",    32'(err),       1);
        check("t2_done",   32'(done),      0);
        check("t2_busy",   32'(busy),      0);
        check("t2_cpu",    32'(cpu_rst_n), 0);
        check("t2_ready",  32'(in_ready),  0);
        in_valid = 1'b1; in_data = 8'h77;
        repeat (3) tick();
        in_valid = 1'b0;
        check("t2_ready_hold", 32'(in_ready), 0);
        check("t2_no_writes", 32'(wr_count - base), 0);

        // Largest legal image (N=256) with gaps in in_valid, starting from ERR
        pulse_start();
        pat_base = wr_count;
        pat_on   = 1'b1;
        send_byte(8'h00);
        send_byte(8'h01);
        x = '0;
        for (int k = 0; k < 1024; k++) begin
            send_byte(pb(k));
            x ^= pb(k);
            if (k % 7 == 3) repeat (k % 3 + 1) tick();
            if (k == 10) begin
                check("t3_gap_ready", 32'(in_ready), 1);
                check("t3_gap_we",    32'(mem_we),   0);
                check("t3_gap_count", 32'(wr_count - pat_base), 2);
            end
        end
        finish_load(x);
        pat_on = 1'b0;
        check("t3_count",     32'(wr_count - pat_base), 256);
        check("t3_last_addr", last_addr, 32'h3fc);
        check("t3_pattern",   32'(pat_bad), 0);
        check("t3_done",      32'(done), 1);
        check("t3_cpu",       32'(cpu_rst_n), 1);

        // Reset in the middle of a word, then a clean reload
        do_reset();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'haa);
        send_byte(8'hbb);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_ready", 32'(in_ready), 0);
        check("t4_async_busy",  32'(busy),     0);
        check("t4_async_wdata", mem_wdata,     0);
        check("t4_async_stat",  {29'd0, done, err, cpu_rst_n}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        base = wr_count;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'haa);
        send_byte(8'hbb);
        send_byte(8'hcc);
        send_byte(8'hdd);
        finish_load(8'h00);
        check("t4_count", 32'(wr_count - base), 1);
        check("t4_addr",  last_addr, 32'h0);
        check("t4_data",  last_data, 32'hddccbbaa);
        check("t4_done",  32'(done), 1);

        // Start from DONE clears status on the same edge; start during DATA is ignored
        pulse_start();
        check("t5_done_clr", 32'(done),      0);
        check("t5_cpu_low",  32'(cpu_rst_n), 0);
        check("t5_busy",     32'(busy),      1);
        base = wr_count;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_mid_ready", 32'(in_ready), 1);
        check("t5_mid_busy",  32'(busy),     1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        finish_load(8'h44);
        check("t5_count", 32'(wr_count - base), 1);
        check("t5_data",  last_data, 32'h44332211);
        check("t5_done",  32'(done), 1);

        // Zero-length image completes without any writes
        pulse_start();
        base = wr_count;
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check("t6_zero_done",  32'(done), 1);
        check("t6_zero_count", 32'(wr_count - base), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0f);
        check("t7_ok_done", 32'(done), 1);
        check("t7_ok_cpu",  32'(cpu_rst_n), 1);
        pulse_start();
        base = wr_count;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0e);
        check("t7_bad_err",   32'(err), 1);
        check("t7_bad_done",  32'(done), 0);
        check("t7_bad_cpu",   32'(cpu_rst_n), 0);
        check("t7_bad_count", 32'(wr_count - base), 1);
        check("t7_bad_data",  last_data, 32'h08040201);
`endif

        check("align", 32'(align_bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
